// File: rtl/phase_rr_arbiter.sv
// Four-way round-robin arbiter for one shared output lane, with grant
// opportunities paced by a free-running 3-bit phase counter and exported phase strobes.
module phase_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            rate_sel,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            gnt,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic                  stb_div2,
    output logic                  stb_div4,
    output logic                  stb_div8,
    output logic                  running
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [2:0]        cnt_q;
    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        rate_q, rate_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic [2:0]        mask;
    logic              tick;
    logic [1:0]        sel;
    logic              found;
    logic              grant_now;

    // Tick fires when all low counter bits selected by the active rate are set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask = 3'b000;
        case (rate_q)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
    end

    assign tick = (state_q == RUN) && enable && ((cnt_q & mask) == mask);

    always_comb begin
        logic [1:0] idx;
        sel   = ptr_q;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign grant_now = tick && found;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SYNC;
            SYNC: begin
                if (!enable)               state_d = IDLE;
                else if (cnt_q == 3'd7)    state_d = RUN;
            end
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The rate is only swapped at a frame boundary so a frame never mixes two rates.
    assign rate_d = ((cnt_q == 3'd7) && (state_q == SYNC || state_q == RUN)) ? rate_sel : rate_q;

    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = 4'b0000;
        data_d  = data_q;
        valid_d = 1'b0;
        if (grant_now) begin
            ptr_d   = sel + 2'd1;
            gnt_d   = 4'b0001 << sel;
            data_d  = data_in[sel*DATA_W +: DATA_W];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 3'd0;
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            rate_q  <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            cnt_q   <= cnt_q + 3'd1;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rate_q  <= rate_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign running   = (state_q == RUN);
    assign stb_div2  = cnt_q[0];
    assign stb_div4  = (cnt_q[1:0] == 2'b11);
    assign stb_div8  = (cnt_q == 3'd7);

endmodule

// File: doc/phase_rr_arbiter.md
Name: phase_rr_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit output lane among 4 requesters.
- Grant opportunities ("ticks") are paced by an internal 3-bit phase counter at rate clk, clk/2, clk/4 or clk/8.
- Exports single-cycle enable strobes at the /2, /4 and /8 phases so downstream blocks can stay on the single clk domain instead of using generated clocks.
- Sits between the lane FIFOs and the serializing datapath.

Parameters:
DATA_W, 8, width of each requester's data word and of data_out

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
enable  input  1  1 = arbitration allowed
rate_sel  input  2  tick rate: 0 every cycle, 1 every 2, 2 every 4, 3 every 8
req  input  4  request per requester, held until granted
data_in  input  4*DATA_W  requester i word at data_in[i*DATA_W +: DATA_W]
gnt  output  4  one-hot grant pulse, 1 cycle
data_out  output  DATA_W  granted word
valid_out  output  1  data_out valid this cycle
stb_div2  output  1  high when cnt[0]==1
stb_div4  output  1  high when cnt[1:0]==3
stb_div8  output  1  high when cnt==7
running  output  1  high in RUN state

Behaviour:
- Reset (reset==0, asynchronous):
  - cnt=0, state=IDLE, ptr=0, rate_q=0.
  - gnt=0, data_out=0, valid_out=0, running=0.
  - Strobes decode to 0.
  - Reset mid-grant aborts the grant with no partial pulse.
- Phase counter:
  - cnt increments by 1 every clk edge out of reset, regardless of state.
  - Wraps 7 -> 0.
  - Strobes are a combinational decode of registered cnt.
- rate_q (active rate):
  - Loaded from rate_sel only on an edge where cnt==7 and the state is SYNC or RUN.
  - A rate_sel change mid-frame takes effect from the cycle cnt==0.
- tick = (state==RUN) & enable & ((cnt & mask)==mask), with mask = 0,1,3,7 for rate_q = 0..3.
  - rate 0: tick every cycle.
  - rate 1: tick when cnt is odd.
  - rate 2: tick at cnt 3 and 7.
  - rate 3: tick at cnt 7.
- FSM:
  - IDLE: running=0, no ticks. enable==1 -> SYNC.
  - SYNC: no ticks. enable==0 -> IDLE. Else at an edge with cnt==7 -> RUN, loading rate_q.
  - RUN: running=1. enable==0 -> IDLE at the next edge; no tick is taken in that cycle.
- Arbitration (in a tick cycle with req != 0):
  - sel = first i with req[i]==1, scanning ptr, ptr+1, ... mod 4.
  - At the next edge: gnt <= onehot(sel), data_out <= data_in[sel], valid_out <= 1, ptr <= (sel+1) mod 4.
  - Latency is 1 cycle from tick to gnt/valid_out.
- Any other cycle: gnt <= 0, valid_out <= 0, data_out holds its last value.
- Handshake:
  - Requester keeps req and data_in stable until it sees gnt[i].
  - gnt[i]==1 means the word is consumed. The requester may keep req high for its next word, which is eligible at the next tick.
  - Dropping req before grant withdraws the request with no error.
- Boundary cases:
  - Only one requester active: it is granted every tick.
  - A tick with req==0 yields no grant and leaves ptr unchanged.
  - ptr survives IDLE/SYNC transitions; only reset clears it.
  - rate_sel and enable changing in the same cycle: both rules apply independently.

Test Plan:
1. Assert reset=0 mid-RUN with valid_out=1 -> gnt, valid_out, data_out, running go to 0 immediately. After release, stb_div2 first high 1 cycle later (cnt=1), stb_div8 first high at cnt=7.
2. rate_sel=0, req=4'b1111, data_in words 0x11/0x22/0x33/0x44, enable=1 from reset -> SYNC until cnt==7, then gnt 0001,0010,0100,1000 on consecutive cycles, data_out 0x11,0x22,0x33,0x44, repeating.
3. rate_sel=2, req=4'b0101 -> grants only after the cnt=3 and cnt=7 ticks, alternating 0001 and 0100, 4 cycles apart.
4. In RUN at rate 0, set rate_sel=3 when cnt==3 -> grants continue every cycle through the cnt=7 tick, then only one grant per frame (after the cnt=7 tick).
5. Drop enable in RUN with all requests pending -> no gnt from that cycle, running=0 next cycle. Re-assert at cnt==2 -> no grant until the cnt==7 edge, then grant resumes at ptr (not at requester 0).
6. req=4'b1000 only, rate 1, then req[0] also rises -> requester 3 granted every tick; next grant after req[0] rises goes to 0 (round-robin wraps from ptr=0).
